dpram_fifo_ctrl: RTL and testbench

//  Initiator side of the dual-port RAM interface: a synchronous FIFO controller that

---
 rtl/dpram_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_dpram_fifo_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_fifo_ctrl.sv
// Purpose: synchronous FIFO controller driving an external dual-port RAM (A = write, B = read) with a 2-entry prefetch.
// Latency: push into an empty FIFO is visible on rd_valid three cycles later; sustains one push and one pop per cycle.
// Backpressure: wr_ready drops when the RAM holds DEPTH words; the read side is held by rd_ready with rd_data stable.
module dpram_fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [WIDTH-1:0]             wr_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+3)-1:0]   level,
    output logic                         ram_we_a,
    output logic [$clog2(DEPTH)-1:0]     ram_addr_a,
    output logic [WIDTH-1:0]             ram_din_a,
    output logic                         ram_we_b,
    output logic [$clog2(DEPTH)-1:0]     ram_addr_b,
    output logic [WIDTH-1:0]             ram_din_b,
    input  logic [WIDTH-1:0]             ram_dout_b
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(DEPTH + 3);

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    ram_count_q, ram_count_d;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] pf_q [2];
    logic [WIDTH-1:0] pf_d [2];
    logic [1:0]       pf_count_q, pf_count_d;
    logic [LW-1:0]    level_q, level_d;

    logic       push;
    logic       pop;
    logic       issue;
    logic       capture;
    logic [1:0] pf_after_pop;

    // wr_ready looks only at the registered RAM count, so a full RAM can never be
    // written while the same address is being read back.
    assign wr_ready = (ram_count_q < CW'(DEPTH));
    assign rd_valid = (pf_count_q != 2'd0);
    assign rd_data  = pf_q[0];
    assign level    = level_q;

    assign push = wr_valid & wr_ready & ~clr;
    assign pop  = rd_valid & rd_ready & ~clr;

    // Credit rule: prefetch slots occupied after this cycle's pop, plus any read
    // already returning, must leave room for the word this issue will bring back.
    assign issue = (ram_count_q != '0) & ~clr &
                   (({1'b0, pf_count_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);

    assign ram_we_a   = push & rst_n;
    assign ram_addr_a = wptr_q;
    assign ram_din_a  = wr_data;
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = rptr_q;
    assign ram_din_b  = '0;

    // Next-state: pointers, RAM occupancy, read-return tracking, prefetch shift/capture, level.
    always_comb begin
        wptr_d       = wptr_q + AW'(push);
        rptr_d       = rptr_q + AW'(issue);
        ram_count_d  = ram_count_q + CW'(push) - CW'(issue);
        inflight_d   = issue;
        level_d      = level_q + LW'(push) - LW'(pop);
        pf_d[0]      = pf_q[0];
        pf_d[1]      = pf_q[1];
        pf_after_pop = pf_count_q - {1'b0, pop};
        capture      = inflight_q & ~clr & (pf_after_pop != 2'd2);

        if (pop) begin
            pf_d[0] = pf_q[1];
        end
        // The returning word lands behind whatever survives the pop.
        if (capture) begin
            pf_d[pf_after_pop[0]] = ram_dout_b;
        end
        pf_count_d = pf_after_pop + {1'b0, capture};

        // Flush wins over everything; a read in flight is simply forgotten.
        if (clr) begin
            wptr_d      = '0;
            rptr_d      = '0;
            ram_count_d = '0;
            inflight_d  = 1'b0;
            pf_count_d  = 2'd0;
            level_d     = '0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            ram_count_q <= '0;
            inflight_q  <= 1'b0;
            pf_q[0]     <= '0;
            pf_q[1]     <= '0;
            pf_count_q  <= 2'd0;
            level_q     <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            ram_count_q <= ram_count_d;
            inflight_q  <= inflight_d;
            pf_q[0]     <= pf_d[0];
            pf_q[1]     <= pf_d[1];
            pf_count_q  <= pf_count_d;
            level_q     <= level_d;
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Purpose: self-checking bench for dpram_fifo_ctrl with a behavioural dual-port RAM and a queue model.
// Latency: directed scenarios pin the 3-cycle first-word latency and full/clear boundaries.
// Backpressure: exercises wr_ready at DEPTH+2 and rd_ready hold behaviour.
module tb_dpram_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH + 3);

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             clr      = 1'b0;
    logic             wr_valid = 1'b0;
    logic             rd_ready = 1'b0;
    logic [WIDTH-1:0] wr_data  = '0;
    logic             wr_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic [LW-1:0]    level;
    logic             ram_we_a;
    logic [AW-1:0]    ram_addr_a;
    logic [WIDTH-1:0] ram_din_a;
    logic             ram_we_b;
    logic [AW-1:0]    ram_addr_b;
    logic [WIDTH-1:0] ram_din_b;
    logic [WIDTH-1:0] ram_dout_b = '0;

    dpram_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .level      (level),
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_we_b   (ram_we_b),
        .ram_addr_b (ram_addr_b),
        .ram_din_b  (ram_din_b),
        .ram_dout_b (ram_dout_b)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: port A write, port B registered read.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_b <= mem[ram_addr_b];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!rd_valid && n < 20) begin
            step();
            n++;
        end
        chk("rd_valid_timeout", rd_valid, 1);
    endtask

    // Queue model: contents in order, writes since clear, and bookkeeping for
    // the hold and first-word latency rules.
    logic [WIDTH-1:0] mq[$];
    int               wcnt      = 0;
    int               starve    = 0;
    logic             prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_level", level, 0);
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_wr_ready", wr_ready, 1);
            chk("rst_rd_data", rd_data, 0);
            chk("rst_ram_we_a", ram_we_a, 0);
            chk("rst_addr_a", ram_addr_a, 0);
            chk("rst_addr_b", ram_addr_b, 0);
            mq.delete();
            wcnt      = 0;
            starve    = 0;
            prev_hold = 1'b0;
        end else begin
            chk("level", level, mq.size());
            if (rd_valid && mq.size() == 0)
                chk("rd_valid_empty", rd_valid, 0);
            else if (rd_valid)
                chk("rd_data_head", rd_data, mq[0]);
            if (mq.size() < DEPTH)      chk("wr_ready_room", wr_ready, 1);
            if (mq.size() >= DEPTH + 2) chk("wr_ready_full", wr_ready, 0);
            if (prev_hold) begin
                chk("hold_valid", rd_valid, 1);
                chk("hold_data", rd_data, prev_data);
            end
            chk("ram_we_a", ram_we_a, wr_valid & wr_ready & ~clr);
            chk("ram_addr_a", ram_addr_a, wcnt % DEPTH);
            chk("ram_din_a", ram_din_a, wr_data);
            chk("ram_we_b", ram_we_b, 0);
            chk("ram_din_b", ram_din_b, 0);
            if (mq.size() != 0 && !rd_valid) starve++;
            else starve = 0;
            if (starve > 2) chk("first_word_latency", starve, 2);

            prev_hold = rd_valid & ~rd_ready & ~clr;
            prev_data = rd_data;
            if (clr) begin
                mq.delete();
                wcnt      = 0;
                starve    = 0;
                prev_hold = 1'b0;
            end else begin
                if (rd_valid && rd_ready) void'(mq.pop_front());
                if (wr_valid && wr_ready) begin
                    mq.push_back(wr_data);
                    wcnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int accepted;
        int exp;

        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // T1: asynchronous reset in the middle of a stream.
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h50 + 8'(i);
            step();
        end
        wr_valid = 1'b0;
        chk("t1_level_pre", level, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_level", level, 0);
        chk("t1_rd_valid", rd_valid, 0);
        chk("t1_wr_ready", wr_ready, 1);
        step();
        rst_n = 1'b1;
        step();

        // T2: first-word latency into an empty FIFO.
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        step();
        wr_valid = 1'b0;
        chk("t2_level_c1", level, 1);
        chk("t2_rd_valid_c1", rd_valid, 0);
        step();
        chk("t2_rd_valid_c2", rd_valid, 0);
        step();
        chk("t2_rd_valid_c3", rd_valid, 1);
        chk("t2_rd_data_c3", rd_data, 8'hA5);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("t2_level_after", level, 0);

        // T3: fill to DEPTH+2 with no reads, then drain in order.
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            if (i >= DEPTH + 2) chk("t3_refuse", wr_ready, 0);
            if (wr_ready) accepted++;
            step();
        end
        wr_valid = 1'b0;
        chk("t3_accepted", accepted, DEPTH + 2);
        chk("t3_level", level, DEPTH + 2);
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            wait_valid();
            chk("t3_pop_data", rd_data, i);
            step();
        end
        rd_ready = 1'b0;
        chk("t3_level_empty", level, 0);

        // T4: streaming push and pop every cycle.
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        exp      = 0;
        for (int c = 0; c < 32; c++) begin
            wr_data = 8'(c);
            chk("t4_wr_ready", wr_ready, 1);
            if (rd_valid) begin
                chk("t4_data", rd_data, exp);
                exp++;
            end
            step();
        end
        chk("t4_pops_in_window", exp, 29);
        wr_valid = 1'b0;
        for (int k = 0; k < 10 && exp < 32; k++) begin
            if (rd_valid) begin
                chk("t4_tail_data", rd_data, exp);
                exp++;
            end
            step();
        end
        chk("t4_total", exp, 32);
        rd_ready = 1'b0;

        // T5: push and pop together while full.
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h40 + 8'(i);
            chk("t5_fill_ready", wr_ready, 1);
            step();
        end
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        rd_ready = 1'b1;
        chk("t5_level_full", level, 10);
        chk("t5_wr_ready", wr_ready, 0);
        chk("t5_rd_valid", rd_valid, 1);
        chk("t5_rd_data", rd_data, 8'h40);
        step();
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        chk("t5_level_after", level, 9);
        chk("t5_next_head", rd_data, 8'h41);
        rd_ready = 1'b1;
        for (int i = 1; i < DEPTH + 2; i++) begin
            wait_valid();
            chk("t5_drain", rd_data, 8'h40 + 8'(i));
            step();
        end
        rd_ready = 1'b0;
        chk("t5_level_empty", level, 0);

        // T6: clear while a RAM read is returning.
        wr_valid = 1'b1;
        wr_data  = 8'h11;
        step();
        wr_valid = 1'b0;
        step();
        clr      = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        rd_ready = 1'b1;
        chk("t6_level_clr_cycle", level, 1);
        chk("t6_ram_we_a_clr", ram_we_a, 0);
        step();
        clr      = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        chk("t6_level", level, 0);
        chk("t6_rd_valid", rd_valid, 0);
        step();
        chk("t6_no_capture", rd_valid, 0);
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        step();
        wr_valid = 1'b0;
        wait_valid();
        chk("t6_next_word", rd_data, 8'h3C);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("t6_level_end", level, 0);

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
